// File: rtl/sraml_mem_responder.sv
// Responder end of the sram-like bus: word-wide memory behind a
// request/accept handshake with a fixed response latency.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing outstanding, ready to accept
// WAIT   | transaction accepted, counting down the remaining latency
// RESP   | data_ok high this cycle; may accept the next request too
module sraml_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         AW       = DEPTH_LOG2 + 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q;
  logic [1:0]             size_q;
  logic [AW-1:0]          addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            mem_q [DEPTH];

  logic                   accept;
  logic                   commit;
  logic                   rd_enter;
  logic [3:0]             be_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [DEPTH_LOG2-1:0]  rd_idx;
  logic [31:0]            wr_word;
  logic [31:0]            rd_word;
  logic                   unused_addr_hi;

  // Misaligned halves/words get no enables but still complete normally.
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
      default: be = (a == 2'b00) ? 4'b1111 : 4'b0000;
    endcase
    return be;
  endfunction

  assign addr_ok_o      = ~rst_i & ((state_q == S_IDLE) | (state_q == S_RESP));
  assign accept         = req_i & addr_ok_o;
  assign data_ok_o      = (state_q == S_RESP);
  assign rdata_o        = rdata_q;
  assign unused_addr_hi = ^addr_i[31:AW];

  assign idx_q  = addr_q[AW-1:2];
  assign be_q   = be_of(size_q, addr_q[1:0]);
  assign commit = (state_q == S_RESP) & wr_q;

  // Next state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == 4'd0) ? S_RESP : S_WAIT;
        end else if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read capture: the transaction entering RESP is either the one counted
  // down in WAIT or, with single-cycle latency, the one being accepted now.
  // A write committing on this same edge to the same word is forwarded.
  always_comb begin
    wr_word = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
    rd_idx   = (state_q == S_WAIT) ? idx_q : addr_i[AW-1:2];
    rd_enter = (state_d == S_RESP) & ((state_q == S_WAIT) ? ~wr_q : ~wr_i);
    rd_word  = (commit && (idx_q == rd_idx)) ? wr_word : mem_q[rd_idx];
    rdata_d  = rd_enter ? rd_word : rdata_q;
  end

  // Control state, captured request fields and read data register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wr_q    <= wr_i;
        size_q  <= size_i;
        addr_q  <= addr_i[AW-1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  // Write commits on the edge that ends the RESP cycle; the array has no reset.
  always_ff @(posedge clk_i) begin
    if (commit) mem_q[idx_q] <= wr_word;
  end

endmodule

// File: tb/tb_sraml_mem_responder.sv
// Bench for sraml_mem_responder: three builds (LATENCY 1, 2, 5) each driven
// by its own initiator and checked every cycle against a transaction-level
// model (pending transaction + due cycle + word array with lane merging).
module tb_sraml_mem_responder;

  localparam int DL = 6;
  localparam int NW = 1 << DL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit done [3];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int lat, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (LATENCY=%0d) cycle %0d: got %h, expected %h",
               name, lat, cyc, act, exp);
    end
  endtask

  // Lane merge from the bus rules: byte = one lane, half = two aligned lanes,
  // word = all four lanes aligned; misaligned accesses change nothing.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] a, input logic [1:0] s);
    logic [31:0] r;
    int lo, n;
    r  = old;
    lo = int'(a[1:0]);
    case (s)
      2'd0:    n = 1;
      2'd1:    n = (lo % 2 == 0) ? 2 : 0;
      default: n = (lo == 0) ? 4 : 0;
    endcase
    for (int b = lo; b < lo + n; b++) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);

    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    sraml_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .wr_i      (wr),
      .size_i    (size),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .addr_ok_o (addr_ok),
      .data_ok_o (data_ok),
      .rdata_o   (rdata)
    );

    logic [31:0] mem_m [NW];
    bit          pend = 0;
    int          due  = 0;
    bit          p_wr;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] last_rd      = 32'd0;
    int          acc_cyc      = 0;
    int          dut_dok_cyc  = 0;
    int          dut_dok_cnt  = 0;
    bit          exp_dok;
    int          idx;

    // Per-cycle compare against the transaction-level model.
    always @(negedge clk) begin
      if (data_ok === 1'b1) begin
        dut_dok_cyc = cyc;
        dut_dok_cnt++;
      end
      if (rst) pend = 0;
      exp_dok = pend && (cyc == due);
      chk("data_ok", LAT, 32'(data_ok), 32'(exp_dok));
      if (exp_dok) begin
        idx = int'((p_addr >> 2) & (NW - 1));
        if (p_wr) begin
          mem_m[idx] = merge(mem_m[idx], p_wdata, p_addr, p_size);
        end else begin
          chk("rdata", LAT, rdata, mem_m[idx]);
          last_rd = rdata;
        end
        pend = 0;
      end
      chk("addr_ok", LAT, 32'(addr_ok), 32'(!rst && !pend));
      if (req && !rst && !pend) begin
        pend    = 1;
        due     = cyc + LAT;
        p_wr    = wr;
        p_size  = size;
        p_addr  = addr;
        p_wdata = wdata;
        acc_cyc = cyc;
      end
    end

    // Returns #1 after the accepting edge with req dropped; calling again
    // right away keeps req asserted continuously.
    task automatic issue(input bit w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d);
      int n;
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      n = 0;
      @(negedge clk);
      while (addr_ok !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (addr_ok !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout (LATENCY=%0d) addr %h: got no addr_ok, expected one within 100 cycles",
                 LAT, a);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
    endtask

    task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] expv, input string name);
      issue(1'b0, 2'd2, a, $urandom);
      idle(LAT + 1);
      chk(name, LAT, last_rd, expv);
    endtask

    initial begin
      int cnt_before;
      rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < NW; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom);
      idle(LAT + 1);

      issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
      idle(LAT + 1);
      chk("write_latency", LAT, 32'(dut_dok_cyc - acc_cyc), 32'(LAT));
      rd_check(32'h10, 32'hDEADBEEF, "word_read");
      chk("read_latency", LAT, 32'(dut_dok_cyc - acc_cyc), 32'(LAT));

      issue(1'b1, 2'd2, 32'h10, 32'h11223344);
      issue(1'b1, 2'd0, 32'h12, 32'h00AA0000);
      rd_check(32'h10, 32'h11AA3344, "byte_write");

      issue(1'b1, 2'd2, 32'h10, 32'h11223344);
      cnt_before = dut_dok_cnt;
      issue(1'b1, 2'd1, 32'h11, 32'hFFFFFFFF);
      idle(LAT + 1);
      chk("misaligned_pulses", LAT, 32'(dut_dok_cnt - cnt_before), 32'd2);
      rd_check(32'h10, 32'h11223344, "misaligned_half");

      issue(1'b1, 2'd2, 32'h20, 32'hCAFEF00D);
      issue(1'b0, 2'd2, 32'h20, 32'd0);
      chk("b2b_accept_in_resp", LAT, 32'(acc_cyc), 32'(dut_dok_cyc));
      idle(LAT + 1);
      chk("b2b_read_data", LAT, last_rd, 32'hCAFEF00D);

      issue(1'b1, 2'd2, 32'h30, 32'h0BADF00D);
      issue(1'b1, 2'd2, 32'h30, 32'h55555555);
      cnt_before = dut_dok_cnt;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("addr_ok_after_reset", LAT, 32'(addr_ok), 32'd1);
      chk("reset_drops_data_ok", LAT, 32'(dut_dok_cnt), 32'(cnt_before));
      idle(1);
      rd_check(32'h30, 32'h0BADF00D, "reset_drops_write");

      for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'($urandom_range(0, NW - 1) * 4), 32'd0);
      idle(LAT + 1);

      for (int i = 0; i < 200; i++) begin
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 31)), $urandom);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(LAT + 2);
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got unfinished initiators, expected all done within 50000 cycles");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
